// File: rtl/dram_stream_agent.sv
// dram_stream_agent: streams NUM_SRC source matrices out of an Avalon-MM memory
// in read rounds, presents aligned operand tuples to a compute unit, buffers the
// returned results in a write FIFO and writes them back to a destination matrix.
module dram_stream_agent #(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 28,
  parameter int NUM_SRC    = 2,
  parameter int MAX_BURST  = 32,
  parameter int WBUF_DEPTH = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [NUM_SRC*ADDR_WIDTH-1:0] src_base,
  input  logic [ADDR_WIDTH-1:0]         dst_base,
  input  logic [ADDR_WIDTH-1:0]         len,
  input  logic [6:0]                    burst_len,
  output logic                          busy,
  output logic                          done,
  output logic [NUM_SRC*DATA_WIDTH-1:0] op_data,
  output logic                          op_valid,
  input  logic [DATA_WIDTH-1:0]         res_data,
  input  logic                          res_valid,
  output logic                          res_ready,
  output logic [ADDR_WIDTH-1:0]         address,
  output logic                          read,
  output logic                          write,
  output logic [DATA_WIDTH-1:0]         writedata,
  output logic [6:0]                    burstcount,
  input  logic [DATA_WIDTH-1:0]         readdata,
  input  logic                          waitrequest,
  input  logic                          readdatavalid
);
  localparam int NSTG = (NUM_SRC > 1) ? NUM_SRC - 1 : 1;
  localparam int SW   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int BW   = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int FW   = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
  localparam int CW   = $clog2(WBUF_DEPTH + 1);
  localparam logic [SW-1:0] LAST_SRC = SW'(NUM_SRC - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;

  // latched command and walking pointers
  logic [ADDR_WIDTH-1:0] src_ptr [NUM_SRC];
  logic [ADDR_WIDTH-1:0] dst_ptr, len_q;
  logic [6:0]            bl_q;
  // issue side: words per source still to request, source slot within round
  logic [ADDR_WIDTH-1:0] rd_rem, issued, wr_cnt;
  logic [SW-1:0]         rd_src;
  // return side: in-order beat tracking mirrors the issue order
  logic [ADDR_WIDTH-1:0] rsp_rem;
  logic [SW-1:0]         rsp_src;
  logic [6:0]            rsp_beat;
  logic [DATA_WIDTH-1:0] stage [NSTG][MAX_BURST];
  // result write FIFO
  logic [DATA_WIDTH-1:0] fifo_mem [WBUF_DEPTH];
  logic [FW-1:0]         wptr, rptr;
  logic [CW-1:0]         cnt;

  logic [ADDR_WIDTH-1:0] bl_ext, rd_bc, rsp_bc, outstanding;
  logic [ADDR_WIDTH:0]   need;
  logic                  acc, free, budget_ok, launch_wr, launch_rd, push, beat, rsp_last_beat;

  // command arbitration: writes drain first, a new round needs FIFO headroom
  always_comb begin
    bl_ext        = ADDR_WIDTH'(bl_q);
    rd_bc         = (rd_rem < bl_ext) ? rd_rem : bl_ext;
    rsp_bc        = (rsp_rem < bl_ext) ? rsp_rem : bl_ext;
    outstanding   = issued - wr_cnt;
    need          = {1'b0, outstanding} + {1'b0, rd_bc};
    budget_ok     = (need <= (ADDR_WIDTH+1)'(WBUF_DEPTH));
    acc           = (read | write) & ~waitrequest;
    free          = ~(read | write) | acc;
    launch_wr     = (state == RUN) & free & (cnt != '0);
    launch_rd     = (state == RUN) & free & (cnt == '0) & (rd_rem != '0) &
                    ((rd_src != '0) | budget_ok);
    push          = (state == RUN) & res_valid & res_ready;
    beat          = (state == RUN) & readdatavalid;
    rsp_last_beat = ((ADDR_WIDTH'(rsp_beat) + 1'b1) == rsp_bc);
  end

  assign res_ready = (cnt != CW'(WBUF_DEPTH));

  // result FIFO; the head is popped into writedata when a write is launched
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) begin
        fifo_mem[wptr] <= res_data;
        wptr <= (wptr == FW'(WBUF_DEPTH - 1)) ? '0 : wptr + 1'b1;
      end
      if (launch_wr)
        rptr <= (rptr == FW'(WBUF_DEPTH - 1)) ? '0 : rptr + 1'b1;
      cnt <= cnt + CW'(push) - CW'(launch_wr);
    end
  end

  // control FSM, Avalon command registers and operand assembly
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      read       <= 1'b0;
      write      <= 1'b0;
      address    <= '0;
      burstcount <= '0;
      writedata  <= '0;
      op_valid   <= 1'b0;
      op_data    <= '0;
      len_q      <= '0;
      bl_q       <= '0;
      dst_ptr    <= '0;
      rd_rem     <= '0;
      rsp_rem    <= '0;
      issued     <= '0;
      wr_cnt     <= '0;
      rd_src     <= '0;
      rsp_src    <= '0;
      rsp_beat   <= '0;
      for (int k = 0; k < NUM_SRC; k++) src_ptr[k] <= '0;
      for (int s = 0; s < NSTG; s++)
        for (int b = 0; b < MAX_BURST; b++) stage[s][b] <= '0;
    end else begin
      op_valid <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            len_q    <= len;
            bl_q     <= burst_len;
            dst_ptr  <= dst_base;
            for (int k = 0; k < NUM_SRC; k++)
              src_ptr[k] <= src_base[k*ADDR_WIDTH +: ADDR_WIDTH];
            rd_rem   <= len;
            rsp_rem  <= len;
            issued   <= '0;
            wr_cnt   <= '0;
            rd_src   <= '0;
            rsp_src  <= '0;
            rsp_beat <= '0;
            if (len == '0) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
              done  <= 1'b0;
            end
          end
        end
        RUN: begin
          if (acc) begin
            read  <= 1'b0;
            write <= 1'b0;
            if (write) begin
              wr_cnt <= wr_cnt + 1'b1;
              if ((wr_cnt + 1'b1) == len_q) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end
          end
          // pointers advance at launch: a presented command is never withdrawn
          if (launch_wr) begin
            write      <= 1'b1;
            read       <= 1'b0;
            burstcount <= 7'd1;
            address    <= dst_ptr;
            dst_ptr    <= dst_ptr + 1'b1;
            writedata  <= fifo_mem[rptr];
          end else if (launch_rd) begin
            read            <= 1'b1;
            write           <= 1'b0;
            burstcount      <= rd_bc[6:0];
            address         <= src_ptr[rd_src];
            src_ptr[rd_src] <= src_ptr[rd_src] + rd_bc;
            if (rd_src == '0) issued <= issued + rd_bc;
            if (rd_src == LAST_SRC) begin
              rd_src <= '0;
              rd_rem <= rd_rem - rd_bc;
            end else begin
              rd_src <= rd_src + 1'b1;
            end
          end
          if (beat) begin
            if (rsp_src == LAST_SRC) begin
              op_valid <= 1'b1;
              for (int k = 0; k < NUM_SRC - 1; k++)
                op_data[k*DATA_WIDTH +: DATA_WIDTH] <= stage[k][rsp_beat[BW-1:0]];
              op_data[(NUM_SRC-1)*DATA_WIDTH +: DATA_WIDTH] <= readdata;
            end else begin
              stage[rsp_src][rsp_beat[BW-1:0]] <= readdata;
            end
            if (rsp_last_beat) begin
              rsp_beat <= '0;
              if (rsp_src == LAST_SRC) begin
                rsp_src <= '0;
                rsp_rem <= rsp_rem - rsp_bc;
              end else begin
                rsp_src <= rsp_src + 1'b1;
              end
            end else begin
              rsp_beat <= rsp_beat + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dram_stream_agent.sv
// Directed bench for dram_stream_agent: memory model with optional stalls,
// compute model with configurable latency, table of runs plus corner sequences.
module tb_dram_stream_agent;
  localparam int DW = 32, AW = 16, NS = 2, MB = 8, WD = 8;

  logic              clk = 1'b0;
  logic              reset, start;
  logic [NS*AW-1:0]  src_base;
  logic [AW-1:0]     dst_base, len;
  logic [6:0]        burst_len;
  logic              busy, done, op_valid, res_ready, read, write;
  logic [NS*DW-1:0]  op_data;
  logic [DW-1:0]     res_data = '0;
  logic              res_valid = 1'b0;
  logic [AW-1:0]     address;
  logic [DW-1:0]     writedata;
  logic [6:0]        burstcount;
  logic [DW-1:0]     readdata = '0;
  logic              waitrequest = 1'b0;
  logic              readdatavalid = 1'b0;

  always #5 clk = ~clk;

  dram_stream_agent #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_SRC(NS),
                      .MAX_BURST(MB), .WBUF_DEPTH(WD)) dut (
    .clk(clk), .reset(reset), .start(start), .src_base(src_base),
    .dst_base(dst_base), .len(len), .burst_len(burst_len), .busy(busy),
    .done(done), .op_data(op_data), .op_valid(op_valid), .res_data(res_data),
    .res_valid(res_valid), .res_ready(res_ready), .address(address),
    .read(read), .write(write), .writedata(writedata), .burstcount(burstcount),
    .readdata(readdata), .waitrequest(waitrequest), .readdatavalid(readdatavalid)
  );

  typedef struct {
    int len; int bl; int s0; int s1; int dst; int delay; int wq;
    int exp_rd; int exp_last_bc;
  } vec_t;
  typedef struct { int due; logic [DW-1:0] d; } res_t;

  vec_t          vecs [6];
  res_t          resq [$];
  logic [DW-1:0] beatq [$];
  int            errors = 0, checks = 0;
  int            cyc = 0, delay = 0, wq_mode = 0, wq_cnt = 0;
  bit            rd_stalled, wr_stalled, prev_rd_hold, prev_wr_hold;
  logic [AW-1:0] prev_addr;
  logic [6:0]    prev_bc;
  logic [DW-1:0] prev_wd;
  int            n_rd, n_wr, n_op, n_beat, stab_err, both_err, viol, occ, occ_max;
  logic [AW-1:0] rd_addr [64];
  int            rd_bcs  [64];
  logic [AW-1:0] wr_addr [64];
  logic [DW-1:0] wr_data [64];

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {a ^ 16'h5A5A, a + 16'h1234};
  endfunction

  // the compute result weights src1 so a swapped operand slice is visible
  function automatic logic [DW-1:0] comp(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return a + (b << 1);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic clear_stats();
    n_rd = 0; n_wr = 0; n_op = 0; n_beat = 0; stab_err = 0; both_err = 0;
    viol = 0; occ = 0; occ_max = 0; rd_stalled = 0; wr_stalled = 0;
  endtask

  // memory, stall generator, compute model and protocol monitors
  always @(negedge clk) begin
    cyc++;
    if (beatq.size() > 0) begin
      readdatavalid = 1'b1;
      readdata = beatq.pop_front();
      n_beat++;
    end else begin
      readdatavalid = 1'b0;
      readdata = '0;
    end
    if (reset) begin
      resq.delete();
      res_valid = 1'b0;
      wq_cnt = 0;
      waitrequest = 1'b0;
      prev_rd_hold = 0;
      prev_wr_hold = 0;
    end else begin
      if (prev_rd_hold && !(read && address == prev_addr && burstcount == prev_bc)) stab_err++;
      if (prev_wr_hold && !(write && address == prev_addr && writedata == prev_wd)) stab_err++;
      if (wq_cnt > 0) wq_cnt--;
      if (wq_mode != 0 && wq_cnt == 0 && read && !rd_stalled) begin
        wq_cnt = 5; rd_stalled = 1;
      end else if (wq_mode != 0 && wq_cnt == 0 && write && !wr_stalled) begin
        wq_cnt = 5; wr_stalled = 1;
      end
      waitrequest = (wq_cnt > 0);
      prev_rd_hold = read && waitrequest;
      prev_wr_hold = write && waitrequest;
      prev_addr = address;
      prev_bc = burstcount;
      prev_wd = writedata;
      if (read && write) both_err++;
      if (read && !waitrequest) begin
        if (n_rd < 64) begin
          rd_addr[n_rd] = address;
          rd_bcs[n_rd] = int'(burstcount);
        end
        n_rd++;
        for (int b = 0; b < int'(burstcount); b++) beatq.push_back(mem_word(address + AW'(b)));
      end
      if (write && !waitrequest) begin
        if (n_wr < 64) begin
          wr_addr[n_wr] = address;
          wr_data[n_wr] = writedata;
        end
        n_wr++;
        occ--;
      end
      if (op_valid) begin
        n_op++;
        resq.push_back('{cyc + delay, comp(op_data[DW-1:0], op_data[2*DW-1:DW])});
      end
      if (resq.size() > 0 && resq[0].due <= cyc) begin
        res_valid = 1'b1;
        res_data = resq[0].d;
        void'(resq.pop_front());
        if (!res_ready) viol++;
        else begin
          occ++;
          if (occ > occ_max) occ_max = occ;
        end
      end else begin
        res_valid = 1'b0;
      end
    end
  end

  task automatic launch(input int l, input int bl, input int s0, input int s1, input int dst);
    src_base = {AW'(s1), AW'(s0)};
    dst_base = AW'(dst);
    len = AW'(l);
    burst_len = 7'(bl);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int c = 0; c < 4000 && !done; c++) @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int r, ebc, base;
    logic [AW-1:0] a0, a1;
    @(posedge clk); #1;
    clear_stats();
    delay = v.delay;
    wq_mode = v.wq;
    launch(v.len, v.bl, v.s0, v.s1, v.dst);
    chk($sformatf("v%0d_busy", id), busy, 1);
    wait_done();
    chk($sformatf("v%0d_done", id), done, 1);
    repeat (2) @(negedge clk);
    chk($sformatf("v%0d_done_hold", id), done, 1);
    chk($sformatf("v%0d_busy_off", id), busy, 0);
    chk($sformatf("v%0d_nwr", id), n_wr, v.len);
    chk($sformatf("v%0d_nop", id), n_op, v.len);
    chk($sformatf("v%0d_nrd", id), n_rd, v.exp_rd);
    chk($sformatf("v%0d_lastbc", id), rd_bcs[(v.exp_rd - 1) % 64], v.exp_last_bc);
    chk($sformatf("v%0d_stable", id), stab_err, 0);
    chk($sformatf("v%0d_rdwr", id), both_err, 0);
    chk($sformatf("v%0d_ready", id), viol, 0);
    chk($sformatf("v%0d_occ", id), occ_max <= WD, 1);
    for (int j = 0; j < v.len; j++) begin
      a0 = AW'(v.s0 + j);
      a1 = AW'(v.s1 + j);
      chk($sformatf("v%0d_wr%0d", id, j), {wr_addr[j], wr_data[j]},
          {AW'(v.dst + j), comp(mem_word(a0), mem_word(a1))});
    end
    for (int i = 0; i < v.exp_rd; i++) begin
      r = i / 2;
      base = (i % 2 == 1) ? v.s1 : v.s0;
      ebc = (v.len - r * v.bl < v.bl) ? v.len - r * v.bl : v.bl;
      chk($sformatf("v%0d_rd%0d", id, i), {rd_addr[i], 7'(rd_bcs[i])},
          {AW'(base + r * v.bl), 7'(ebc)});
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; src_base = '0; dst_base = '0; len = '0; burst_len = '0;
    clear_stats();
    //          len bl  s0       s1       dst      dly wq rd lastbc
    vecs[0] = '{8,  4, 'h0010,  'h0200,  'h1000,  0,  0, 4,  4};
    vecs[1] = '{10, 4, 'h0020,  'h0400,  'h1100,  0,  0, 6,  2};
    vecs[2] = '{5,  8, 'hFFFE,  'h7FFD,  'hFFFC,  0,  0, 2,  5};
    vecs[3] = '{6,  1, 'h0033,  'h0077,  'h1200,  0,  0, 12, 1};
    vecs[4] = '{16, 4, 'h0100,  'h0300,  'h2000,  50, 0, 8,  4};
    vecs[5] = '{7,  3, 'h0500,  'h0600,  'h3000,  0,  1, 6,  1};
    repeat (3) @(posedge clk); #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rdwr", {read, write}, 0);
    chk("rst_ready", res_ready, 1);
    chk("rst_opv", op_valid, 0);
    reset = 1'b0;

    // zero-length command finishes immediately without bus traffic
    @(posedge clk); #1;
    clear_stats();
    launch(0, 4, 'h10, 'h20, 'h30);
    chk("len0_done", done, 1);
    chk("len0_busy", busy, 0);
    repeat (5) @(negedge clk);
    chk("len0_traffic", n_rd + n_wr, 0);

    foreach (vecs[i]) run_vec(vecs[i], i);

    // start while running must not disturb the active command
    @(posedge clk); #1;
    clear_stats();
    delay = 0; wq_mode = 0;
    launch(4, 2, 'h30, 'h50, 'h100);
    repeat (2) @(posedge clk); #1;
    launch(2, 1, 'h70, 'h90, 'h300);
    wait_done();
    chk("rerun_done", done, 1);
    chk("rerun_nwr", n_wr, 4);
    chk("rerun_nrd", n_rd, 4);
    chk("rerun_lastwr", {wr_addr[3], wr_data[3]},
        {16'h0103, comp(mem_word(16'h0033), mem_word(16'h0053))});

    // reset in the middle of a burst, stray beats must be dropped
    @(posedge clk); #1;
    clear_stats();
    launch(8, 4, 'h40, 'h80, 'h500);
    for (int c = 0; c < 50 && n_beat < 1; c++) @(negedge clk);
    chk("mid_beat_seen", n_beat >= 1, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    chk("mid_rdwr", {read, write}, 0);
    chk("mid_opv", op_valid, 0);
    chk("mid_ready", res_ready, 1);
    chk("mid_addr", {address, burstcount}, 0);
    chk("mid_wdata", writedata, 0);
    chk("mid_opdata", op_data, 0);
    reset = 1'b0;
    n_op = 0;
    for (int c = 0; c < 60 && beatq.size() > 0; c++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("mid_stray_opv", n_op, 0);
    chk("mid_idle", busy, 0);
    run_vec(vecs[0], 9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
